// File: rtl/mult_wide_acc_pipe.sv
// Unsigned A_WIDTH x B_WIDTH multiplier built from SLICE_W-wide partial products, with a 3-stage
// valid/ready pipeline under one global stall and an optional running-sum (accumulate) mode.
module mult_wide_acc_pipe #(
  parameter int unsigned A_WIDTH   = 149,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned SLICE_W   = 26,
  parameter int unsigned ACC_WIDTH = 173
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_acc,
  input  logic                 in_first,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_p,
  output logic                 out_ovf
);

  localparam int unsigned NUM_SLICE = (A_WIDTH + SLICE_W - 1) / SLICE_W;
  localparam int unsigned PAD_W     = NUM_SLICE * SLICE_W;
  localparam int unsigned PART_W    = SLICE_W + B_WIDTH;
  localparam int unsigned SUM_W     = PAD_W + B_WIDTH;

  if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_acc_width_check
    $error("ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
  end

  logic adv;

  // Stage 1: input registers
  logic               s1_valid;
  logic [A_WIDTH-1:0] s1_a;
  logic [B_WIDTH-1:0] s1_b;
  logic               s1_acc;
  logic               s1_first;

  // Stage 2: unshifted per-slice partial products
  logic                                s2_valid;
  logic [NUM_SLICE-1:0][PART_W-1:0]    s2_part;
  logic                                s2_acc;
  logic                                s2_first;

  // Stage 3 state: accumulation group
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;

  logic [PAD_W-1:0]                 a_pad;
  logic [NUM_SLICE-1:0][PART_W-1:0] part_d;
  logic [SUM_W-1:0]                 prod_full;
  logic [SUM_W-1:0]                 part_ext;
  logic [ACC_WIDTH:0]               prod_ext;
  logic [ACC_WIDTH-1:0]             acc_base;
  logic [ACC_WIDTH:0]               sum;
  logic                             ovf_new;

  // Whole pipeline moves together; bubbles are not squeezed out.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    a_pad              = '0;
    a_pad[A_WIDTH-1:0] = s1_a;
    for (int i = 0; i < NUM_SLICE; i++) begin
      part_d[i] = {{B_WIDTH{1'b0}}, a_pad[i*SLICE_W +: SLICE_W]} *
                  {{SLICE_W{1'b0}}, s1_b};
    end
  end

  always_comb begin
    prod_full = '0;
    part_ext  = '0;
    for (int i = 0; i < NUM_SLICE; i++) begin
      part_ext              = '0;
      part_ext[PART_W-1:0]  = s2_part[i];
      prod_full             = prod_full + (part_ext << (i * SLICE_W));
    end
  end

  // Padding bits of prod_full are zero by construction; fit it into the sum width.
  if (SUM_W <= ACC_WIDTH + 1) begin : g_prod_zext
    always_comb begin
      prod_ext            = '0;
      prod_ext[SUM_W-1:0] = prod_full;
    end
  end else begin : g_prod_trunc
    always_comb begin
      prod_ext = prod_full[ACC_WIDTH:0];
    end
  end

  always_comb begin
    acc_base = s2_first ? '0 : acc_q;
    sum      = {1'b0, acc_base} + prod_ext;
    ovf_new  = (s2_first ? 1'b0 : ovf_q) | sum[ACC_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_acc   <= 1'b0;
      s1_first <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_acc   <= in_acc;
        s1_first <= in_first;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_part  <= '0;
      s2_acc   <= 1'b0;
      s2_first <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_part  <= part_d;
        s2_acc   <= s1_acc;
        s2_first <= s1_first;
      end
    end
  end

  // acc/ovf move only when a real accumulate beat lands in the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_ovf   <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        if (s2_acc) begin
          out_p   <= sum[ACC_WIDTH-1:0];
          out_ovf <= ovf_new;
          acc_q   <= sum[ACC_WIDTH-1:0];
          ovf_q   <= ovf_new;
        end else begin
          out_p   <= prod_ext[ACC_WIDTH-1:0];
          out_ovf <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_wide_acc_pipe.sv
// Self-checking bench for mult_wide_acc_pipe: vector table, hand sequences and a random
// stream checked against an arithmetic model of products and accumulation groups.
module tb_mult_wide_acc_pipe;

  localparam int unsigned A_WIDTH   = 149;
  localparam int unsigned B_WIDTH   = 16;
  localparam int unsigned SLICE_W   = 26;
  localparam int unsigned ACC_WIDTH = 173;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   in_a;
  logic [B_WIDTH-1:0]   in_b;
  logic                 in_acc;
  logic                 in_first;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_p;
  logic                 out_ovf;

  always #5 clk = ~clk;

  mult_wide_acc_pipe #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .SLICE_W  (SLICE_W),
    .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_acc   (in_acc),
    .in_first (in_first),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .out_ovf  (out_ovf)
  );

  typedef struct {
    logic [ACC_WIDTH-1:0] p;
    logic                 ovf;
  } exp_t;

  typedef struct {
    logic [A_WIDTH-1:0]   a;
    logic [B_WIDTH-1:0]   b;
    logic                 m;
    logic                 f;
    logic [ACC_WIDTH-1:0] exp_p;
    logic                 exp_ovf;
  } vec_t;

  exp_t                 sb[$];
  logic [ACC_WIDTH-1:0] got_p[$];
  logic                 got_ovf[$];
  int                   xfer_cyc[$];
  logic [ACC_WIDTH-1:0] acc_m;
  logic                 ovf_m;
  int                   total = 0;
  int                   bad = 0;
  int                   cyc_n = 0;
  logic                 s_ov;
  logic [ACC_WIDTH-1:0] s_p;
  logic                 s_ovf;
  logic                 stall_prev = 1'b0;
  logic [ACC_WIDTH-1:0] held_p;
  logic                 held_ovf;

  function automatic void check(string name, logic [ACC_WIDTH-1:0] got, logic [ACC_WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  // Reference: full-precision product, group sum taken mod 2^ACC_WIDTH, sticky carry-out.
  function automatic exp_t model(logic [A_WIDTH-1:0] a, logic [B_WIDTH-1:0] b, logic m, logic f);
    logic [ACC_WIDTH:0]   prod;
    logic [ACC_WIDTH:0]   s;
    logic [ACC_WIDTH-1:0] base;
    exp_t                 e;
    prod = {{(ACC_WIDTH + 1 - A_WIDTH){1'b0}}, a} * {{(ACC_WIDTH + 1 - B_WIDTH){1'b0}}, b};
    if (m) begin
      base  = f ? '0 : acc_m;
      s     = {1'b0, base} + prod;
      acc_m = s[ACC_WIDTH-1:0];
      ovf_m = (f ? 1'b0 : ovf_m) | s[ACC_WIDTH];
      e.p   = acc_m;
      e.ovf = ovf_m;
    end else begin
      e.p   = prod[ACC_WIDTH-1:0];
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [A_WIDTH-1:0] rand_a();
    logic [A_WIDTH-1:0] r;
    for (int i = 0; i < A_WIDTH; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // One clock: drive at negedge, sample #1 later, account for handshakes of the coming edge.
  task automatic cyc(input logic v, input logic [A_WIDTH-1:0] a, input logic [B_WIDTH-1:0] b,
                     input logic m, input logic f, input logic ordy, output logic taken);
    exp_t e;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_acc    = m;
    in_first  = f;
    out_ready = ordy;
    #1;
    s_ov  = out_valid;
    s_p   = out_p;
    s_ovf = out_ovf;
    check("in_ready", in_ready, !out_valid || out_ready);
    if (stall_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_p", out_p, held_p);
      check("hold_ovf", out_ovf, held_ovf);
    end
    if (out_valid && out_ready) begin
      got_p.push_back(out_p);
      got_ovf.push_back(out_ovf);
      xfer_cyc.push_back(cyc_n);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_output got=%h exp=none", out_p);
      end else begin
        e = sb.pop_front();
        check("out_p", out_p, e.p);
        check("out_ovf", out_ovf, e.ovf);
      end
    end
    stall_prev = out_valid && !out_ready;
    held_p     = out_p;
    held_ovf   = out_ovf;
    taken      = v && in_ready;
    if (taken) sb.push_back(model(a, b, m, f));
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic idle(input logic ordy);
    logic t;
    cyc(1'b0, '0, '0, 1'b0, 1'b0, ordy, t);
  endtask

  task automatic send(input logic [A_WIDTH-1:0] a, input logic [B_WIDTH-1:0] b, input logic m,
                      input logic f, input logic rnd);
    logic taken;
    taken = 1'b0;
    for (int k = 0; k < 100 && !taken; k++) begin
      cyc(1'b1, a, b, m, f, rnd ? 1'($urandom_range(0, 1)) : 1'b1, taken);
    end
    if (!taken) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=not_accepted exp=accepted");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) idle(1'b1);
    check("drain_empty", sb.size(), 0);
    repeat (3) idle(1'b1);
  endtask

  vec_t                 tbl[6];
  logic [A_WIDTH-1:0]   a_v;
  logic [A_WIDTH-1:0]   ones_a;
  logic [ACC_WIDTH-1:0] lat_exp;
  logic                 t;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_acc    = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b0;
    acc_m     = '0;
    ovf_m     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Latency: result must appear on the third edge counting the capture edge.
    a_v                = '0;
    a_v[148]           = 1'b1;
    lat_exp            = '0;
    lat_exp[163:148]   = 16'hFFFF;
    cyc(1'b1, a_v, 16'hFFFF, 1'b0, 1'b0, 1'b1, t);
    idle(1'b1);
    check("lat_edge1_valid", s_ov, 0);
    idle(1'b1);
    check("lat_edge2_valid", s_ov, 0);
    idle(1'b1);
    check("lat_edge3_valid", s_ov, 1);
    check("lat_p", s_p, lat_exp);
    check("lat_ovf", s_ovf, 0);
    drain();

    // Table of accumulate/product vectors, including a mode-0 beat inside a group.
    tbl[0] = '{149'd3, 16'd5, 1'b1, 1'b1, 173'd15, 1'b0};
    tbl[1] = '{149'd7, 16'd2, 1'b1, 1'b0, 173'd29, 1'b0};
    tbl[2] = '{149'd1, 16'd1, 1'b1, 1'b1, 173'd1, 1'b0};
    tbl[3] = '{149'd10, 16'd10, 1'b0, 1'b0, 173'd100, 1'b0};
    tbl[4] = '{149'd2, 16'd3, 1'b1, 1'b0, 173'd7, 1'b0};
    tbl[5] = '{149'd1000, 16'd1000, 1'b0, 1'b1, 173'd1000000, 1'b0};
    got_p.delete();
    got_ovf.delete();
    for (int i = 0; i < 6; i++) send(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].f, 1'b0);
    drain();
    check("tbl_count", got_p.size(), 6);
    for (int i = 0; i < 6 && i < got_p.size(); i++) begin
      check($sformatf("tbl%0d_p", i), got_p[i], tbl[i].exp_p);
      check($sformatf("tbl%0d_ovf", i), got_ovf[i], tbl[i].exp_ovf);
    end

    // 8 random products back-to-back: outputs on 8 consecutive cycles.
    xfer_cyc.delete();
    for (int i = 0; i < 8; i++) send(rand_a(), 16'($urandom()), 1'b0, 1'b0, 1'b0);
    drain();
    check("b2b_count", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8) check("b2b_consecutive", xfer_cyc[7] - xfer_cyc[0], 7);

    // 50 random beats of mixed mode under random backpressure.
    for (int i = 0; i < 50; i++) begin
      send(rand_a(), 16'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           1'b1);
      if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
    end
    drain();

    // Overflow: 1 + 2^(ACC-A-B+1) all-ones beats must wrap and set the sticky flag.
    ones_a = '1;
    got_ovf.delete();
    got_p.delete();
    send(ones_a, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < (1 << (ACC_WIDTH - A_WIDTH - B_WIDTH + 1)); i++) begin
      send(ones_a, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    end
    drain();
    if (got_ovf.size() > 0) begin
      check("ovf_first_beat", got_ovf[0], 0);
      check("ovf_sticky_end", got_ovf[got_ovf.size()-1], 1);
    end
    send(149'd1, 16'd1, 1'b1, 1'b1, 1'b0);
    drain();
    check("ovf_cleared", got_ovf[got_ovf.size()-1], 0);
    check("ovf_new_group_p", got_p[got_p.size()-1], 1);

    // Reset with two beats in flight, one of them already presented and stalled.
    send(149'd5, 16'd5, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 149'd4, 16'd4, 1'b1, 1'b0, 1'b0, t);
    idle(1'b0);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_p", out_p, 0);
    check("rst_mid_ovf", out_ovf, 0);
    sb.delete();
    acc_m      = '0;
    ovf_m      = 1'b0;
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got_p.delete();
    repeat (5) idle(1'b1);
    check("rst_no_stale", got_p.size(), 0);
    send(149'd2, 16'd3, 1'b1, 1'b0, 1'b0);
    drain();
    check("rst_acc_zero_count", got_p.size(), 1);
    if (got_p.size() > 0) check("rst_acc_zero_p", got_p[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
